// File: rtl/cache_mem_adapter_if.sv
// Bundle between the cache controller, the line adapter and main memory.
// The adapter connects through the slave modport; the cache and memory side drive the master modport.
interface cache_mem_adapter_if #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 8
);
    localparam int LINE_W = WORDS_PER_LINE * DATA_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);

    logic                    mem_read;
    logic                    mem_write;
    logic [ADDR_W-OFF_W-1:0] line_addr;
    logic [LINE_W-1:0]       wb_line;
    logic                    ca_resp;
    logic [LINE_W-1:0]       fill_line;
    logic                    error;
    logic [ADDR_W-1:0]       mm_addr;
    logic [DATA_W-1:0]       mm_wdata;
    logic                    mm_re;
    logic                    mm_we;
    logic [DATA_W-1:0]       mm_rdata;
    logic                    mm_ack;

    modport master (
        output mem_read, mem_write, line_addr, wb_line, mm_rdata, mm_ack,
        input  ca_resp, fill_line, error, mm_addr, mm_wdata, mm_re, mm_we
    );

    modport slave (
        input  mem_read, mem_write, line_addr, wb_line, mm_rdata, mm_ack,
        output ca_resp, fill_line, error, mm_addr, mm_wdata, mm_re, mm_we
    );
endinterface

// File: rtl/cache_mem_adapter.sv
// Serialises cache line write-backs and fills into single-word main-memory transactions,
// with a per-word ack timeout that aborts the burst and pulses error.
module cache_mem_adapter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int TIMEOUT_CYC    = 255
) (
    input  logic               clk,
    input  logic               rst,
    cache_mem_adapter_if.slave bus
);
    localparam int LINE_W = WORDS_PER_LINE * DATA_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(WORDS_PER_LINE);
    localparam int BO_W   = OFF_W - IDX_W;
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [LA_W-1:0]   line_q;
    logic [LINE_W-1:0] wb_q;
    logic [LINE_W-1:0] fill_q;
    logic [IDX_W-1:0]  idx;
    logic [TO_W-1:0]   tcnt;
    logic              error_q;
    logic              in_burst;
    logic              word_ack;
    logic              last_word;
    logic              timeout;
    logic              accept;

    assign in_burst  = (state == WR_BURST) || (state == RD_BURST);
    assign word_ack  = in_burst && bus.mm_ack;
    assign last_word = (idx == IDX_W'(WORDS_PER_LINE - 1));
    assign timeout   = in_burst && !bus.mm_ack && (tcnt == TO_W'(TIMEOUT_CYC - 1));
    assign accept    = (state == IDLE) && (bus.mem_write || bus.mem_read);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.mem_write)     state_nxt = WR_BURST;
                else if (bus.mem_read) state_nxt = RD_BURST;
            end
            WR_BURST, RD_BURST: begin
                if ((word_ack && last_word) || timeout) state_nxt = DONE;
            end
            DONE: begin
                // Holding in DONE while a request is still raised avoids re-triggering on the same level.
                if (!bus.mem_read && !bus.mem_write) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ca_resp = 1'b0;
        bus.mm_re   = 1'b0;
        bus.mm_we   = 1'b0;
        case (state)
            WR_BURST: begin
                bus.ca_resp = 1'b1;
                bus.mm_we   = 1'b1;
            end
            RD_BURST: begin
                bus.ca_resp = 1'b1;
                bus.mm_re   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_q  <= '0;
            wb_q    <= '0;
            fill_q  <= '0;
            idx     <= '0;
            tcnt    <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= timeout;
            if (accept) begin
                line_q <= bus.line_addr;
                if (bus.mem_write) wb_q <= bus.wb_line;
                idx  <= '0;
                tcnt <= '0;
            end else if (word_ack) begin
                tcnt <= '0;
                if (state == RD_BURST) fill_q[int'(idx)*DATA_W +: DATA_W] <= bus.mm_rdata;
                // idx parks on the last word; only the next burst entry clears it.
                if (!last_word) idx <= idx + 1'b1;
            end else if (in_burst) begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    assign bus.mm_addr   = ADDR_W'({line_q, idx}) << BO_W;
    assign bus.mm_wdata  = wb_q[int'(idx)*DATA_W +: DATA_W];
    assign bus.fill_line = fill_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_cache_mem_adapter.sv
// Directed bench for cache_mem_adapter: reset, fills, write-backs, chaining, priority,
// ack timeout and reset during a burst, with a small cycle-stepped memory responder.
module tb_cache_mem_adapter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WPL    = 8;
    localparam int TO     = 4;
    localparam int LINE_W = WPL * DATA_W;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    cache_mem_adapter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(WPL)) bus ();

    cache_mem_adapter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(WPL), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] b, input logic [LINE_W-1:0] old, input int n);
        logic [LINE_W-1:0] r;
        r = old;
        for (int i = 0; i < n; i++) r[i*32 +: 32] = b + 32'(i);
        return r;
    endfunction

    // Called at a negedge inside the first burst cycle; returns at the negedge of the first non-busy cycle.
    task automatic serve(input bit wr, input int lat, input int hold, input logic [31:0] base,
                         input logic [31:0] rd_base, output int words, output int strobes,
                         output bit saw_err, output int wrong);
        int wait_c;
        bit ended;
        wait_c = 0; ended = 0;
        words = 0; strobes = 0; saw_err = 0; wrong = 0;
        for (int c = 0; c < 200 && !ended; c++) begin
            if (bus.error === 1'b1) saw_err = 1;
            if (bus.ca_resp !== 1'b1) begin
                ended = 1;
            end else begin
                if (bus.mm_re !== !wr || bus.mm_we !== wr) wrong++;
                strobes++;
                wait_c++;
                if (words != hold && wait_c > lat) begin
                    check("addr", bus.mm_addr, base + 32'(words * 4));
                    if (wr) check("wdata", bus.mm_wdata, 32'(32'h11 * words));
                    bus.mm_ack   = 1'b1;
                    bus.mm_rdata = rd_base + 32'(words);
                    words++;
                    wait_c = 0;
                end else begin
                    bus.mm_ack = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.mm_ack = 1'b0;
        check("burst_end", ended, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int words, strobes, wrong;
        bit saw_err;
        logic [LINE_W-1:0] fill_exp;
        logic [LINE_W-1:0] wb;

        rst = 1'b0;
        bus.mem_read = 1'b1; bus.mem_write = 1'b0;
        bus.line_addr = 27'h10; bus.wb_line = '0;
        bus.mm_ack = 1'b0; bus.mm_rdata = '0;
        for (int i = 0; i < WPL; i++) wb[i*32 +: 32] = 32'(32'h11 * i);

        // reset held with a pending read
        repeat (3) @(negedge clk);
        check("rst_ca_resp", bus.ca_resp, 0);
        check("rst_mm_re", bus.mm_re, 0);
        check("rst_mm_we", bus.mm_we, 0);
        check("rst_error", bus.error, 0);
        check("rst_mm_addr", bus.mm_addr, 0);
        check("rst_mm_wdata", bus.mm_wdata, 0);
        check("rst_fill", bus.fill_line, 0);
        rst = 1'b1;
        @(negedge clk);
        check("t1_accept", bus.ca_resp, 1);

        // line fill, 2-cycle memory latency
        serve(0, 2, -1, 32'h200, 32'hA0, words, strobes, saw_err, wrong);
        fill_exp = mk_line(32'hA0, '0, 8);
        check("t2_words", words, 8);
        check("t2_strobes", strobes, 24);
        check("t2_wrong", wrong, 0);
        check("t2_err", saw_err, 0);
        check("t2_fill", bus.fill_line, fill_exp);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_done_busy", bus.ca_resp, 0);
            check("t2_done_re", bus.mm_re, 0);
            check("t2_done_fill", bus.fill_line, fill_exp);
        end
        bus.mem_read = 1'b0;
        @(negedge clk);

        // write-back, zero-latency acks
        bus.mem_write = 1'b1; bus.line_addr = 27'h20; bus.wb_line = wb;
        @(negedge clk);
        serve(1, 0, -1, 32'h400, 32'h0, words, strobes, saw_err, wrong);
        check("t3_words", words, 8);
        check("t3_strobes", strobes, 8);
        check("t3_wrong", wrong, 0);
        check("t3_fill", bus.fill_line, fill_exp);
        check("t3_we_off", bus.mm_we, 0);

        // write-back then fill chained through DONE and IDLE
        bus.mem_write = 1'b0;
        @(negedge clk);
        bus.mem_write = 1'b1; bus.line_addr = 27'h30;
        @(negedge clk);
        serve(1, 0, -1, 32'h600, 32'h0, words, strobes, saw_err, wrong);
        check("t4_wr_words", words, 8);
        bus.mem_write = 1'b0;
        @(negedge clk);
        check("t4_idle_busy", bus.ca_resp, 0);
        bus.mem_read = 1'b1; bus.line_addr = 27'h31;
        @(negedge clk);
        serve(0, 1, -1, 32'h620, 32'hB0, words, strobes, saw_err, wrong);
        fill_exp = mk_line(32'hB0, '0, 8);
        check("t4_rd_words", words, 8);
        check("t4_rd_strobes", strobes, 16);
        check("t4_wrong", wrong, 0);
        check("t4_fill", bus.fill_line, fill_exp);
        bus.mem_read = 1'b0;
        @(negedge clk);

        // simultaneous requests: write wins
        bus.mem_read = 1'b1; bus.mem_write = 1'b1; bus.line_addr = 27'h40;
        @(negedge clk);
        serve(1, 0, -1, 32'h800, 32'h0, words, strobes, saw_err, wrong);
        check("t5_words", words, 8);
        check("t5_no_re", wrong, 0);
        check("t5_fill", bus.fill_line, fill_exp);
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        @(negedge clk);

        // ack withheld on word 3
        bus.mem_read = 1'b1; bus.line_addr = 27'h50;
        @(negedge clk);
        serve(0, 0, 3, 32'hA00, 32'hC0, words, strobes, saw_err, wrong);
        fill_exp = mk_line(32'hC0, fill_exp, 3);
        check("t6_words", words, 3);
        check("t6_strobes", strobes, 7);
        check("t6_err_seen", saw_err, 1);
        check("t6_error", bus.error, 1);
        check("t6_re_off", bus.mm_re, 0);
        check("t6_fill", bus.fill_line, fill_exp);
        @(negedge clk);
        check("t6_err_pulse", bus.error, 0);
        check("t6_stay_done", bus.ca_resp, 0);
        bus.mem_read = 1'b0;
        @(negedge clk);

        // reset in the middle of a fill
        bus.mem_read = 1'b1; bus.line_addr = 27'h60;
        @(negedge clk);
        check("t6r_re_on", bus.mm_re, 1);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t6r_re", bus.mm_re, 0);
            check("t6r_we", bus.mm_we, 0);
            check("t6r_busy", bus.ca_resp, 0);
        end
        check("t6r_fill", bus.fill_line, 0);
        check("t6r_addr", bus.mm_addr, 0);
        bus.mem_read = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("t6r_idle", bus.ca_resp, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
